// File: rtl/se_sram_mrw_2_req_arbiter.sv
// Four-requester, two-port arbiter for a se_sram_mrw_2 dual-port SRAM with round-robin grants,
// same-address hazard deferral and read-response routing. SE_SRAM_ARB_CLEAR_EN adds a post-reset clear.
module se_sram_mrw_2_req_arbiter #(
    parameter int unsigned address_width = 9,
    parameter int unsigned data_width    = 32
) (
    input  logic                         sram_clock,
    input  logic                         reset,
    input  logic [3:0]                   req_valid,
    input  logic [3:0]                   req_read_not_write,
    input  logic [4*address_width-1:0]   req_address,
    input  logic [4*data_width-1:0]      req_write_data,
    output logic [3:0]                   req_ack,
    output logic [3:0]                   rsp_valid,
    output logic [4*data_width-1:0]      rsp_data,
    output logic                         clear_busy,
    output logic                         select_0,
    output logic                         select_1,
    output logic                         read_not_write_0,
    output logic                         read_not_write_1,
    output logic [address_width-1:0]     address_0,
    output logic [address_width-1:0]     address_1,
    output logic [data_width-1:0]        write_data_0,
    output logic [data_width-1:0]        write_data_1,
    input  logic [data_width-1:0]        data_out_0,
    input  logic [data_width-1:0]        data_out_1
);

    localparam int unsigned ClearWidth = address_width - 1;

    logic [ClearWidth-1:0] clear_index;

`ifdef SE_SRAM_ARB_CLEAR_EN
    typedef enum logic {StClear, StRun} clear_state_e;

    clear_state_e          clear_state, clear_state_next;
    logic [ClearWidth-1:0] clear_index_next;

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            clear_state <= StClear;
            clear_index <= '0;
        end else begin
            clear_state <= clear_state_next;
            clear_index <= clear_index_next;
        end
    end

    always_comb begin
        clear_state_next = clear_state;
        clear_index_next = clear_index;
        case (clear_state)
            StClear: begin
                clear_index_next = clear_index + ClearWidth'(1);
                if (clear_index == {ClearWidth{1'b1}}) clear_state_next = StRun;
            end
            default: ;
        endcase
    end

    assign clear_busy = (clear_state == StClear);
`else
    assign clear_index = '0;
    assign clear_busy  = 1'b0;
`endif

    logic [1:0] rr_ptr;
    logic [1:0] scan_idx;
    logic [1:0] first_idx, second_idx;
    logic       first_found, second_found;

    // Walk the requesters starting at the round-robin pointer; pick the first two valid ones.
    always_comb begin
        scan_idx     = '0;
        first_idx    = '0;
        second_idx   = '0;
        first_found  = 1'b0;
        second_found = 1'b0;
        for (int o = 0; o < 4; o++) begin
            scan_idx = rr_ptr + 2'(o);
            if (req_valid[scan_idx]) begin
                if (!first_found) begin
                    first_idx   = scan_idx;
                    first_found = 1'b1;
                end else if (!second_found) begin
                    second_idx   = scan_idx;
                    second_found = 1'b1;
                end
            end
        end
    end

    logic [address_width-1:0] first_addr, second_addr;
    logic [data_width-1:0]    first_wdata, second_wdata;
    logic                     first_read, second_read;
    logic                     hazard, grant_0, grant_1;

    assign first_addr   = req_address[first_idx*address_width +: address_width];
    assign second_addr  = req_address[second_idx*address_width +: address_width];
    assign first_wdata  = req_write_data[first_idx*data_width +: data_width];
    assign second_wdata = req_write_data[second_idx*data_width +: data_width];
    assign first_read   = req_read_not_write[first_idx];
    assign second_read  = req_read_not_write[second_idx];

    // Only read+read may share an address within one cycle.
    assign hazard  = (first_addr == second_addr) && !(first_read && second_read);
    assign grant_0 = first_found && !clear_busy && !reset;
    assign grant_1 = second_found && !hazard && !clear_busy && !reset;

    always_comb begin
        req_ack = '0;
        if (grant_0) req_ack[first_idx] = 1'b1;
        if (grant_1) req_ack[second_idx] = 1'b1;
    end

    logic [1:0] tag_valid;
    logic [1:0] tag_req_0, tag_req_1;

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            rr_ptr    <= '0;
            tag_valid <= '0;
            tag_req_0 <= '0;
            tag_req_1 <= '0;
        end else begin
            tag_valid[0] <= grant_0 && first_read;
            tag_valid[1] <= grant_1 && second_read;
            tag_req_0    <= first_idx;
            tag_req_1    <= second_idx;
            if (grant_1) begin
                rr_ptr <= second_idx + 2'd1;
            end else if (grant_0) begin
                rr_ptr <= first_idx + 2'd1;
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (!reset) begin
            if (tag_valid[0]) begin
                rsp_valid[tag_req_0] = 1'b1;
                rsp_data[tag_req_0*data_width +: data_width] = data_out_0;
            end
            if (tag_valid[1]) begin
                rsp_valid[tag_req_1] = 1'b1;
                rsp_data[tag_req_1*data_width +: data_width] = data_out_1;
            end
        end
    end

    always_comb begin
        select_0         = 1'b0;
        select_1         = 1'b0;
        read_not_write_0 = 1'b1;
        read_not_write_1 = 1'b1;
        address_0        = '0;
        address_1        = '0;
        write_data_0     = '0;
        write_data_1     = '0;
        if (!reset) begin
            if (clear_busy) begin
                // Clear writes an even/odd address pair per cycle.
                select_0         = 1'b1;
                select_1         = 1'b1;
                read_not_write_0 = 1'b0;
                read_not_write_1 = 1'b0;
                address_0        = {clear_index, 1'b0};
                address_1        = {clear_index, 1'b1};
            end else begin
                if (grant_0) begin
                    select_0         = 1'b1;
                    read_not_write_0 = first_read;
                    address_0        = first_addr;
                    write_data_0     = first_wdata;
                end
                if (grant_1) begin
                    select_1         = 1'b1;
                    read_not_write_1 = second_read;
                    address_1        = second_addr;
                    write_data_1     = second_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_se_sram_mrw_2_req_arbiter.sv
// Randomized self-checking bench for se_sram_mrw_2_req_arbiter with an SRAM model and a
// list-based reference model of arbitration; covers SE_SRAM_ARB_CLEAR_EN when defined.
module tb_se_sram_mrw_2_req_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;
`ifdef SE_SRAM_ARB_CLEAR_EN
    localparam int CLR_CYCLES = 256;
`else
    localparam int CLR_CYCLES = 0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req_valid, req_read_not_write, req_ack, rsp_valid;
    logic [4*AW-1:0] req_address;
    logic [4*DW-1:0] req_write_data, rsp_data;
    logic            clear_busy, select_0, select_1, read_not_write_0, read_not_write_1;
    logic [AW-1:0]   address_0, address_1;
    logic [DW-1:0]   write_data_0, write_data_1, data_out_0, data_out_1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    se_sram_mrw_2_req_arbiter #(.address_width(AW), .data_width(DW)) dut (
        .sram_clock(clk), .reset(reset), .req_valid(req_valid),
        .req_read_not_write(req_read_not_write), .req_address(req_address),
        .req_write_data(req_write_data), .req_ack(req_ack), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .clear_busy(clear_busy), .select_0(select_0), .select_1(select_1),
        .read_not_write_0(read_not_write_0), .read_not_write_1(read_not_write_1),
        .address_0(address_0), .address_1(address_1), .write_data_0(write_data_0),
        .write_data_1(write_data_1), .data_out_0(data_out_0), .data_out_1(data_out_1)
    );

    function automatic logic [DW-1:0] init_word(input int a);
`ifdef SE_SRAM_ARB_CLEAR_EN
        return '0;
`else
        return 32'hC0DE_0000 | DW'(a);
`endif
    endfunction

    // SRAM behaviour: registered read, write on select.
    logic [DW-1:0] sram    [1 << AW];
    logic [DW-1:0] ref_mem [1 << AW];
    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            sram[a]    = 32'hC0DE_0000 | DW'(a);
            ref_mem[a] = 32'hC0DE_0000 | DW'(a);
        end
    end
    always @(posedge clk) begin
        if (select_0) begin
            if (read_not_write_0) data_out_0 <= sram[address_0];
            else sram[address_0] <= write_data_0;
        end
        if (select_1) begin
            if (read_not_write_1) data_out_1 <= sram[address_1];
            else sram[address_1] <= write_data_1;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return req_address[i*AW +: AW];
    endfunction

    // Reference model: ordered candidate list from the pointer, hazard rule, one-cycle read latency.
    int            m_ptr, m_clr;
    logic [3:0]    m_rv, n_rv;
    logic [DW-1:0] m_rd [4];
    logic [DW-1:0] n_rd [4];
    int            cand [4];
    int            n, g0, g1, k;
    logic [3:0]    exp_ack;
    logic [127:0]  exp_data;

    always @(negedge clk) begin
        if (reset) begin
            chk("reset_ack", req_ack, 0);
            chk("reset_select", {select_0, select_1}, 0);
            chk("reset_rsp_valid", rsp_valid, 0);
            m_ptr = 0;
            m_rv  = '0;
            m_clr = CLR_CYCLES;
        end else begin
            exp_data = '0;
            for (int i = 0; i < 4; i++) if (m_rv[i]) exp_data[i*DW +: DW] = m_rd[i];
            chk("rsp_valid", rsp_valid, m_rv);
            chk("rsp_data", rsp_data, exp_data);
            n_rv = '0;
            for (int i = 0; i < 4; i++) n_rd[i] = '0;
            if (m_clr > 0) begin
                k = CLR_CYCLES - m_clr;
                chk("clear_busy_on", clear_busy, 1);
                chk("clear_ack", req_ack, 0);
                chk("clear_select", {select_0, select_1, read_not_write_0, read_not_write_1}, 4'b1100);
                chk("clear_addr", {address_0, address_1}, {AW'(2 * k), AW'(2 * k + 1)});
                ref_mem[2 * k]     = '0;
                ref_mem[2 * k + 1] = '0;
                m_clr--;
            end else begin
                chk("clear_busy_off", clear_busy, 0);
                n = 0;
                for (int o = 0; o < 4; o++) begin
                    if (req_valid[(m_ptr + o) % 4]) begin
                        cand[n] = (m_ptr + o) % 4;
                        n++;
                    end
                end
                g0 = -1;
                g1 = -1;
                if (n >= 1) g0 = cand[0];
                if (n >= 2) begin
                    if (addr_of(cand[0]) != addr_of(cand[1]) ||
                        (req_read_not_write[cand[0]] && req_read_not_write[cand[1]]))
                        g1 = cand[1];
                end
                exp_ack = '0;
                if (g0 >= 0) exp_ack[g0] = 1'b1;
                if (g1 >= 0) exp_ack[g1] = 1'b1;
                chk("ack", req_ack, exp_ack);
                chk("select", {select_0, select_1}, {g0 >= 0, g1 >= 0});
                if (g0 >= 0) begin
                    chk("port0_req", {read_not_write_0, address_0},
                        {req_read_not_write[g0], addr_of(g0)});
                    if (req_read_not_write[g0]) begin
                        n_rv[g0] = 1'b1;
                        n_rd[g0] = ref_mem[addr_of(g0)];
                    end else begin
                        chk("port0_wdata", write_data_0, req_write_data[g0*DW +: DW]);
                    end
                end
                if (g1 >= 0) begin
                    chk("port1_req", {read_not_write_1, address_1},
                        {req_read_not_write[g1], addr_of(g1)});
                    if (req_read_not_write[g1]) begin
                        n_rv[g1] = 1'b1;
                        n_rd[g1] = ref_mem[addr_of(g1)];
                    end else begin
                        chk("port1_wdata", write_data_1, req_write_data[g1*DW +: DW]);
                    end
                end
                if (g0 >= 0 && !req_read_not_write[g0]) ref_mem[addr_of(g0)] = req_write_data[g0*DW +: DW];
                if (g1 >= 0 && !req_read_not_write[g1]) ref_mem[addr_of(g1)] = req_write_data[g1*DW +: DW];
                if (g1 >= 0) m_ptr = (g1 + 1) % 4;
                else if (g0 >= 0) m_ptr = (g0 + 1) % 4;
            end
            m_rv = n_rv;
            for (int i = 0; i < 4; i++) m_rd[i] = n_rd[i];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear(output int cycles);
        cycles = 0;
        while (clear_busy === 1'b1 && cycles < 400) begin
            step();
            cycles++;
        end
        if (cycles >= 400) begin
            checks++;
            failures++;
            $display("FAIL clear_timeout actual=%0d required=%0d", cycles, CLR_CYCLES);
        end
    endtask

    task automatic do_reset();
        int c;
        reset     = 1'b1;
        req_valid = '0;
        step();
        reset = 1'b0;
        wait_clear(c);
    endtask

    task automatic set_req(input int i, input logic rd, input int a, input logic [DW-1:0] d);
        req_read_not_write[i]      = rd;
        req_address[i*AW +: AW]    = AW'(a);
        req_write_data[i*DW +: DW] = d;
    endtask

    logic [3:0] acks;
    int         clr_cnt;

    initial begin
        reset              = 1'b1;
        req_valid          = 4'b1111;
        req_read_not_write = 4'b1111;
        req_address        = '0;
        req_write_data     = '0;
        // Reset held three cycles with every requester asking.
        repeat (3) begin
            @(negedge clk);
            chk("t1_ack", req_ack, 0);
            chk("t1_select", {select_0, select_1}, 0);
            chk("t1_rsp_valid", rsp_valid, 0);
            step();
        end
        reset     = 1'b0;
        req_valid = '0;
        wait_clear(clr_cnt);

        // Dual issue.
        set_req(0, 1'b1, 'h10, '0);
        set_req(2, 1'b1, 'h20, '0);
        req_valid = 4'b0101;
        @(negedge clk);
        chk("t2_ack", req_ack, 4'b0101);
        chk("t2_addr", {address_0, address_1}, {9'h010, 9'h020});
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t2_rsp_valid", rsp_valid, 4'b0101);
        chk("t2_rsp0", rsp_data[31:0], init_word('h10));
        chk("t2_rsp2", rsp_data[95:64], init_word('h20));
        step();

        // Round-robin with four continuous readers.
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 'h50 + i, '0);
        req_valid = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t3_ack", req_ack, (c % 2 == 0) ? 4'b0011 : 4'b1100);
            step();
        end
        req_valid = '0;
        step();

        // Write/read hazard on one address.
        do_reset();
        set_req(1, 1'b0, 'h33, 32'hA5A5_A5A5);
        set_req(3, 1'b1, 'h33, '0);
        req_valid = 4'b1010;
        @(negedge clk);
        chk("t4_ack_n", req_ack, 4'b0010);
        step();
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("t4_ack_n1", req_ack, 4'b1000);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t4_rsp_valid", rsp_valid, 4'b1000);
        chk("t4_rsp3", rsp_data[127:96], 32'hA5A5_A5A5);
        step();

        // Read+read same address.
        do_reset();
        set_req(0, 1'b1, 'h40, '0);
        set_req(1, 1'b1, 'h40, '0);
        req_valid = 4'b0011;
        @(negedge clk);
        chk("t5_ack", req_ack, 4'b0011);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t5_rsp_valid", rsp_valid, 4'b0011);
        chk("t5_rsp_data", rsp_data[63:0], {init_word('h40), init_word('h40)});
        step();

`ifdef SE_SRAM_ARB_CLEAR_EN
        // Clear duration, restart on mid-clear reset, then the top word reads back zero.
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_clear(clr_cnt);
        chk("t6_clear_len", clr_cnt, 256);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (100) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_clear(clr_cnt);
        chk("t6_clear_restart_len", clr_cnt, 256);
        set_req(0, 1'b1, 'h1FF, '0);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t6_rsp_1ff", {rsp_valid[0], rsp_data[31:0]}, {1'b1, 32'h0});
        step();
`endif

        // Randomized traffic on a small address pool with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acks = req_ack;
            step();
            if ($urandom_range(0, 249) == 0) begin
                reset     = 1'b1;
                req_valid = '0;
            end else begin
                reset = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (req_valid[i] && acks[i]) req_valid[i] = 1'b0;
                    if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
                        set_req(i, 1'($urandom_range(0, 1)), 'h100 + $urandom_range(0, 3), $urandom);
                        req_valid[i] = 1'b1;
                    end
                end
            end
        end
        reset     = 1'b0;
        req_valid = '0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
